// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key schedule sequencer: holds one round key and derives the next
// on every accepted round-key beat, so round keys 0..NR stream out in order.
module aes_key_sched_ctrl #(
    parameter int unsigned NR        = 10,
    parameter logic [7:0]  RCON_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         abort,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last,
    output logic         busy
);

    localparam logic [3:0] LastIdx = 4'(NR);

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e        state_q, state_d;
    logic [127:0]  key_q, key_d;
    logic [3:0]    round_q, round_d;
    logic [7:0]    rcon_q, rcon_d;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box: multiplicative inverse as x^254 (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] sq;
        inv = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    logic [31:0]  rot_w3, sub_w, temp_w;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] next_rk;

    assign rot_w3  = {key_q[23:0], key_q[31:24]};
    assign sub_w   = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                      sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
    assign temp_w  = sub_w ^ {rcon_q, 24'h0};
    assign nw0     = key_q[127:96] ^ temp_w;
    assign nw1     = key_q[95:64] ^ nw0;
    assign nw2     = key_q[63:32] ^ nw1;
    assign nw3     = key_q[31:0] ^ nw2;
    assign next_rk = {nw0, nw1, nw2, nw3};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        round_d   = round_q;
        rcon_d    = rcon_q;
        key_ready = 1'b0;
        rk_valid  = 1'b0;
        rk_data   = '0;
        rk_idx    = '0;

        unique case (state_q)
            StIdle: begin
                key_ready = !abort;
                if (key_valid && key_ready) begin
                    key_d   = key_in;
                    round_d = '0;
                    rcon_d  = RCON_INIT;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                rk_valid = !abort;
                rk_data  = key_q;
                rk_idx   = round_q;
                if (rk_valid && rk_ready) begin
                    if (round_q == LastIdx) begin
                        state_d = StIdle;
                    end else begin
                        key_d   = next_rk;
                        rcon_d  = xtime(rcon_q);
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort wins over any coincident accept or beat.
        if (abort) begin
            state_d = StIdle;
            round_d = '0;
            rcon_d  = RCON_INIT;
        end

        rk_last = rk_valid && (round_q == LastIdx);
        busy    = (state_q == StEmit);

        if (!rst_n) begin
            key_ready = 1'b0;
            rk_valid  = 1'b0;
            rk_data   = '0;
            rk_idx    = '0;
            rk_last   = 1'b0;
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: FIPS-197 key vectors, stalls, abort,
// mid-job reset and held key_valid.
module tb_aes_key_sched_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         abort;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;
    logic         busy;

    always #5 clk = ~clk;

    aes_key_sched_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .abort     (abort),
        .rk_data   (rk_data),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEYZ = 128'h0;
    localparam logic [127:0] ZRK1 = 128'h62636363626363636263636362636363;

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    vec_t         vecs[$];
    logic [127:0] got[0:10];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [127:0] key, input int idx, input logic [127:0] rk);
        vec_t v;
        v.key = key;
        v.idx = idx;
        v.rk  = rk;
        vecs.push_back(v);
    endtask

    task automatic check_table(input logic [127:0] key, input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].key == key)
                chk($sformatf("%s_rk%0d", tag, vecs[i].idx), got[vecs[i].idx], vecs[i].rk);
        end
    endtask

    // Runs one whole job, capturing every beat into got[]; optional random rk_ready stalls.
    task automatic run_job(input logic [127:0] key, input bit stall, input string tag);
        int           beats;
        int           cyc;
        bit           prev_stall;
        logic [127:0] hold_d;
        logic [3:0]   hold_i;
        beats      = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        hold_d     = '0;
        hold_i     = '0;
        for (int i = 0; i < 11; i++) got[i] = 'x;
        @(posedge clk); #1;
        key_in    = key;
        key_valid = 1'b1;
        rk_ready  = 1'b0;
        #1 chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_in    = {$urandom(), $urandom(), $urandom(), $urandom()};
        while (beats < 11 && cyc < 100) begin
            rk_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                chk({tag, "_stall_data"}, rk_data, hold_d);
                chk({tag, "_stall_idx"}, 128'(rk_idx), 128'(hold_i));
            end
            chk({tag, "_valid"}, 128'(rk_valid), 128'(1));
            prev_stall = 1'b0;
            if (rk_valid && rk_ready) begin
                got[beats] = rk_data;
                chk({tag, "_idx"}, 128'(rk_idx), 128'(beats));
                chk({tag, "_last"}, 128'(rk_last), 128'(beats == 10));
                if (!stall) chk({tag, "_beat_cycle"}, 128'(cyc), 128'(beats));
                beats++;
            end else if (rk_valid) begin
                prev_stall = 1'b1;
                hold_d     = rk_data;
                hold_i     = rk_idx;
            end
            cyc++;
            @(posedge clk); #1;
        end
        chk({tag, "_beats_done"}, 128'(beats), 128'(11));
        rk_ready = 1'b0;
        #1;
        chk({tag, "_key_ready_after"}, 128'(key_ready), 128'(1));
        chk({tag, "_busy_after"}, 128'(busy), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        add_vec(KEY1, 0,  128'h2b7e151628aed2a6abf7158809cf4f3c);
        add_vec(KEY1, 1,  128'ha0fafe1788542cb123a339392a6c7605);
        add_vec(KEY1, 2,  128'hf2c295f27a96b9435935807a7359f67f);
        add_vec(KEY1, 3,  128'h3d80477d4716fe3e1e237e446d7a883b);
        add_vec(KEY1, 4,  128'hef44a541a8525b7fb671253bdb0bad00);
        add_vec(KEY1, 5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc);
        add_vec(KEY1, 6,  128'h6d88a37a110b3efddbf98641ca0093fd);
        add_vec(KEY1, 7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f);
        add_vec(KEY1, 8,  128'head27321b58dbad2312bf5607f8d292f);
        add_vec(KEY1, 9,  128'hac7766f319fadc2128d12941575c006e);
        add_vec(KEY1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        add_vec(KEYZ, 0,  128'h0);
        add_vec(KEYZ, 1,  ZRK1);
        add_vec(KEYZ, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        rst_n     = 1'b0;
        key_in    = '0;
        key_valid = 1'b0;
        abort     = 1'b0;
        rk_ready  = 1'b0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_key_ready", 128'(key_ready), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_rk_valid", 128'(rk_valid), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("idle_key_ready", 128'(key_ready), 128'(1));
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_rk_data", rk_data, 128'h0);
        chk("idle_rk_idx", 128'(rk_idx), 128'(0));

        // FIPS-197 key, zero key, then the FIPS key under random stalls
        run_job(KEY1, 1'b0, "key1");
        check_table(KEY1, "key1");
        run_job(KEYZ, 1'b0, "zero");
        check_table(KEYZ, "zero");
        run_job(KEY1, 1'b1, "stall");
        check_table(KEY1, "stall");

        // Abort at rk_idx=5
        @(posedge clk); #1;
        key_in = KEY1; key_valid = 1'b1; rk_ready = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_pre_idx", 128'(rk_idx), 128'(5));
        abort = 1'b1;
        #1;
        chk("abort_masks_valid", 128'(rk_valid), 128'(0));
        chk("abort_masks_last", 128'(rk_last), 128'(0));
        chk("abort_busy_same_cycle", 128'(busy), 128'(1));
        @(posedge clk); #1;
        abort = 1'b0; rk_ready = 1'b0;
        #1;
        chk("abort_busy_next", 128'(busy), 128'(0));
        chk("abort_key_ready_next", 128'(key_ready), 128'(1));
        // Abort beats a coincident key_valid in IDLE
        @(posedge clk); #1;
        key_valid = 1'b1; abort = 1'b1;
        #1 chk("abort_masks_key_ready", 128'(key_ready), 128'(0));
        @(posedge clk); #1;
        key_valid = 1'b0; abort = 1'b0;
        #1;
        chk("abort_no_accept_busy", 128'(busy), 128'(0));
        chk("abort_no_accept_valid", 128'(rk_valid), 128'(0));
        run_job(KEY1, 1'b0, "restart");
        check_table(KEY1, "restart");

        // Reset pulse at rk_idx=7
        @(posedge clk); #1;
        key_in = KEY1; key_valid = 1'b1; rk_ready = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("midrst_pre_idx", 128'(rk_idx), 128'(7));
        rst_n = 1'b0;
        #1;
        chk("midrst_key_ready", 128'(key_ready), 128'(0));
        chk("midrst_rk_valid", 128'(rk_valid), 128'(0));
        chk("midrst_rk_data", rk_data, 128'h0);
        chk("midrst_rk_idx", 128'(rk_idx), 128'(0));
        chk("midrst_rk_last", 128'(rk_last), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1; rk_ready = 1'b0;
        #1;
        chk("postrst_rk_valid", 128'(rk_valid), 128'(0));
        chk("postrst_busy", 128'(busy), 128'(0));
        chk("postrst_rk_data", rk_data, 128'h0);
        chk("postrst_rk_idx", 128'(rk_idx), 128'(0));
        chk("postrst_key_ready", 128'(key_ready), 128'(1));
        run_job(KEYZ, 1'b0, "postrst");
        check_table(KEYZ, "postrst");

        // key_valid held high: one accept at T, the next only at T+12
        @(posedge clk); #1;
        key_in = KEYZ; key_valid = 1'b1; rk_ready = 1'b1;
        #1 chk("hold_accept1", 128'(key_ready), 128'(1));
        @(posedge clk); #1;
        key_in = KEY1;
        for (int c = 1; c <= 11; c++) begin
            #1;
            chk($sformatf("hold_no_accept_c%0d", c), 128'(key_ready), 128'(0));
            chk($sformatf("hold_idx_c%0d", c), 128'(rk_idx), 128'(c - 1));
            if (c == 2) chk("hold_first_job_rk1", rk_data, ZRK1);
            @(posedge clk); #1;
        end
        #1 chk("hold_accept2", 128'(key_ready), 128'(1));
        @(posedge clk); #1;
        key_valid = 1'b0;
        #1;
        chk("hold_job2_valid", 128'(rk_valid), 128'(1));
        chk("hold_job2_idx", 128'(rk_idx), 128'(0));
        chk("hold_job2_rk0", rk_data, KEY1);
        for (int i = 0; i < 30 && busy; i++) begin
            @(posedge clk); #1;
        end
        chk("hold_job2_drained", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
